// File: rtl/io_bus_ctrl_if.sv
// io_bus_ctrl_if: CPU data-memory side bus as seen by the IO controller.
// The CPU side drives the access strobes, address, store data and the data
// memory read word; the controller returns the muxed load result.
interface io_bus_ctrl_if;
  logic        io_read;
  logic        io_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] rdata;

  modport master (
    output io_read,
    output io_write,
    output addr,
    output wdata,
    output mem_rdata,
    input  rdata
  );

  modport slave (
    input  io_read,
    input  io_write,
    input  addr,
    input  wdata,
    input  mem_rdata,
    output rdata
  );
endinterface

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped IO controller beside data memory.
// NUM_CH latched switch channels with new-data flags (clear-on-read),
// a test-switch readback, an LED register and a combinational load mux.
// Optional feature macro: IO_DEBOUNCE_EN (per-channel enter debouncers).
//
// Bus semantics: io_read and io_write are single-cycle qualifiers with no
// backpressure. A load is answered in the same cycle on rdata; any side
// effect (flag clear) and any store take effect at the rising edge where
// the qualifier is high. The two are never asserted together.
module io_bus_ctrl #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned IN_W      = 8,
  parameter int unsigned LED_W     = 24,
  parameter int unsigned TEST_W    = 3,
  parameter logic [31:0] IO_BASE   = 32'hFFFF_FC00,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic               clock,
  input  logic               rst_n,
  io_bus_ctrl_if.slave       bus,
  input  logic [IN_W-1:0]    sw_in,
  input  logic [NUM_CH-1:0]  enter,
  input  logic [TEST_W-1:0]  test_in,
  output logic [LED_W-1:0]   led_out,
  output logic [NUM_CH-1:0]  new_flags
);

  localparam logic [31:0] TEST_ADDR   = IO_BASE + 32'h20;
  localparam logic [31:0] STATUS_ADDR = IO_BASE + 32'h24;
  localparam logic [31:0] LED_ADDR    = IO_BASE + 32'h30;

  logic [IN_W-1:0]   sw_s1, sw_s2;
  logic [TEST_W-1:0] test_s1, test_s2;
  logic [NUM_CH-1:0] en_s1, en_s2;
  logic [NUM_CH-1:0] en_cond;
  logic [NUM_CH-1:0] en_prev;
  logic [NUM_CH-1:0] en_rise;
  logic [NUM_CH-1:0] rd_ch;
  logic [IN_W-1:0]   ch_data [NUM_CH];
  logic [LED_W-1:0]  led_reg;
  logic [31:0]       rdata_mux;
  logic              unused_bits;

  // Two-flop synchronisers for every board input.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      test_s1 <= '0;
      test_s2 <= '0;
      en_s1   <= '0;
      en_s2   <= '0;
    end else begin
      sw_s1   <= sw_in;
      sw_s2   <= sw_s1;
      test_s1 <= test_in;
      test_s2 <= test_s1;
      en_s1   <= enter;
      en_s2   <= en_s1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [CNT_W-1:0]  db_cnt [NUM_CH];
  logic [NUM_CH-1:0] db_level;

  // Debouncer: the level follows the synchronised button only after it has
  // disagreed for DB_CYCLES consecutive edges; any agreeing cycle restarts.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      db_level <= '0;
      for (int k = 0; k < int'(NUM_CH); k++) db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_CH); k++) begin
        if (en_s2[k] != db_level[k]) begin
          if (db_cnt[k] == CNT_W'(DB_CYCLES - 1)) begin
            db_level[k] <= en_s2[k];
            db_cnt[k]   <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + CNT_W'(1);
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  assign en_cond     = db_level;
  assign unused_bits = ^bus.wdata;
`else
  assign en_cond     = en_s2;
  // DB_CYCLES has no meaning without debouncers.
  assign unused_bits = (^bus.wdata) ^ (DB_CYCLES == 0);
`endif

  assign en_rise = en_cond & ~en_prev;

  // Which channel data register a load is targeting this cycle.
  always_comb begin
    rd_ch = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      rd_ch[k] = bus.io_read && (bus.addr == IO_BASE + 32'(4 * k));
    end
  end

  // Edge detect, channel latch and new-data flags; a set beats a same-edge clear.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      en_prev   <= '0;
      new_flags <= '0;
      for (int k = 0; k < int'(NUM_CH); k++) ch_data[k] <= '0;
    end else begin
      en_prev <= en_cond;
      for (int k = 0; k < int'(NUM_CH); k++) begin
        if (en_rise[k]) begin
          ch_data[k]   <= sw_s2;
          new_flags[k] <= 1'b1;
        end else if (rd_ch[k]) begin
          new_flags[k] <= 1'b0;
        end
      end
    end
  end

  // LED register: only a store to the LED address changes it.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      led_reg <= '0;
    end else if (bus.io_write && (bus.addr == LED_ADDR)) begin
      led_reg <= bus.wdata[LED_W-1:0];
    end
  end

  assign led_out = led_reg;

  // Load mux: mapped IO registers override data memory only on an IO load.
  always_comb begin
    rdata_mux = bus.mem_rdata;
    if (bus.io_read) begin
      for (int k = 0; k < int'(NUM_CH); k++) begin
        if (rd_ch[k]) begin
          rdata_mux             = '0;
          rdata_mux[IN_W-1:0]   = ch_data[k];
        end
      end
      if (bus.addr == TEST_ADDR) begin
        rdata_mux             = '0;
        rdata_mux[TEST_W-1:0] = test_s2;
      end
      if (bus.addr == STATUS_ADDR) begin
        rdata_mux             = '0;
        rdata_mux[NUM_CH-1:0] = new_flags;
      end
      if (bus.addr == LED_ADDR) begin
        rdata_mux            = '0;
        rdata_mux[LED_W-1:0] = led_reg;
      end
    end
  end

  assign bus.rdata = rdata_mux;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb_io_bus_ctrl: directed bench for io_bus_ctrl (NUM_CH=2, IN_W=8,
// LED_W=24, TEST_W=3, DB_CYCLES=8). Load results go through an expected
// queue; flags and LED outputs are compared directly.
module tb_io_bus_ctrl;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned IN_W   = 8;
  localparam int unsigned LED_W  = 24;
  localparam int unsigned TEST_W = 3;
  localparam logic [31:0] BASE   = 32'hFFFF_FC00;
  localparam int unsigned DB     = 8;
`ifdef IO_DEBOUNCE_EN
  localparam int DB_LAT = 8;
`else
  localparam int DB_LAT = 0;
`endif

  logic              clock;
  logic              rst_n;
  logic [IN_W-1:0]   sw_in;
  logic [NUM_CH-1:0] enter;
  logic [TEST_W-1:0] test_in;
  logic [LED_W-1:0]  led_out;
  logic [NUM_CH-1:0] new_flags;

  logic [31:0] exp_q[$];
  int total;
  int bad;

  io_bus_ctrl_if bus_if ();

  io_bus_ctrl #(
    .NUM_CH(NUM_CH), .IN_W(IN_W), .LED_W(LED_W), .TEST_W(TEST_W),
    .IO_BASE(BASE), .DB_CYCLES(DB)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus(bus_if.slave),
    .sw_in(sw_in),
    .enter(enter),
    .test_in(test_in),
    .led_out(led_out),
    .new_flags(new_flags)
  );

  // Clock and reset-free clock generation.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one load; expected word is queued at drive time and popped when
  // the combinational result is sampled. The access spans one rising edge.
  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] e;
    bus_if.io_read = 1'b1;
    bus_if.addr    = a;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    chk(tag, bus_if.rdata, e);
    tick();
    bus_if.io_read = 1'b0;
    bus_if.addr    = 32'h0;
  endtask

  task automatic write_io(input logic [31:0] a, input logic [31:0] d);
    bus_if.io_write = 1'b1;
    bus_if.addr     = a;
    bus_if.wdata    = d;
    tick();
    bus_if.io_write = 1'b0;
    bus_if.addr     = 32'h0;
    bus_if.wdata    = 32'h0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    sw_in = '0;
    enter = '0;
    test_in = '0;
    bus_if.io_read   = 1'b0;
    bus_if.io_write  = 1'b0;
    bus_if.addr      = 32'h0;
    bus_if.wdata     = 32'h0;
    bus_if.mem_rdata = 32'hDEAD_BEEF;

    // Reset state
    repeat (2) tick();
    chk("rst_led", {8'b0, led_out}, 32'h0);
    chk("rst_flags", {30'b0, new_flags}, 32'h0);
    chk("rst_rdata_mem", bus_if.rdata, 32'hDEAD_BEEF);
    rst_n = 1'b1;
    tick();
    read_chk("ch0_init", BASE, 32'h0);
    read_chk("ch1_init", BASE + 32'h4, 32'h0);

    // LED store truncates to LED_W
    write_io(BASE + 32'h30, 32'h1234_5678);
    chk("led_out", {8'b0, led_out}, 32'h0034_5678);
    read_chk("led_read", BASE + 32'h30, 32'h0034_5678);

    // Store to read-only channel is ignored
    write_io(BASE, 32'hFFFF_FFFF);
    chk("led_keep", {8'b0, led_out}, 32'h0034_5678);
    read_chk("ch0_ro", BASE, 32'h0);

    // Unmapped and out-of-range loads fall through to memory
    bus_if.mem_rdata = 32'h1122_3344;
    read_chk("unmapped_38", BASE + 32'h38, 32'h1122_3344);
    read_chk("ch2_unmapped", BASE + 32'h8, 32'h1122_3344);
    bus_if.addr = BASE + 32'h30;
    #1;
    chk("no_read_mux", bus_if.rdata, 32'h1122_3344);
    bus_if.addr = 32'h0;

    // Test switches, zero-extended
    test_in = 3'b101;
    repeat (3) tick();
    read_chk("test_read", BASE + 32'h20, 32'h5);

`ifdef IO_DEBOUNCE_EN
    // Bouncing button never settles long enough to latch
    sw_in = 8'hEE;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      enter[0] = 1'b1;
      repeat (3) tick();
      enter[0] = 1'b0;
      repeat (2) tick();
    end
    repeat (12) tick();
    chk("bounce_flags", {30'b0, new_flags}, 32'h0);
    read_chk("bounce_ch0", BASE, 32'h0);
`endif

    // Latch on channel 1 with exact latency; held level latches once
    sw_in = 8'h5A;
    repeat (3) tick();
    enter[1] = 1'b1;
    repeat (2 + DB_LAT) tick();
    chk("latch_early", {30'b0, new_flags}, 32'h0);
    tick();
    chk("latch_flags", {30'b0, new_flags}, 32'h2);
    tick();
    sw_in = 8'h77;
    repeat (6) tick();
    enter[1] = 1'b0;
    repeat (4 + DB_LAT) tick();

    // Status read does not clear; channel read clears the next cycle
    read_chk("status", BASE + 32'h24, 32'h2);
    chk("status_keep", {30'b0, new_flags}, 32'h2);
    read_chk("ch0_untouched", BASE, 32'h0);
    chk("ch0_keep", {30'b0, new_flags}, 32'h2);
    read_chk("ch1_latched", BASE + 32'h4, 32'h0000_005A);
    chk("clear_on_read", {30'b0, new_flags}, 32'h0);

    // Latch edge coinciding with a CH[0] read edge: set wins
    sw_in = 8'hC3;
    repeat (3) tick();
    enter[0] = 1'b1;
    repeat (2 + DB_LAT) tick();
    read_chk("collide_old", BASE, 32'h0);
    chk("collide_set", {30'b0, new_flags}, 32'h1);
    read_chk("collide_new", BASE, 32'h0000_00C3);
    chk("collide_clear", {30'b0, new_flags}, 32'h0);
    enter[0] = 1'b0;
    repeat (4 + DB_LAT) tick();

    // Asynchronous reset mid-operation
    write_io(BASE + 32'h30, 32'h00AB_CDEF);
    chk("led_abcdef", {8'b0, led_out}, 32'h00AB_CDEF);
    sw_in = 8'h99;
    repeat (3) tick();
    enter[1] = 1'b1;
    repeat (3 + DB_LAT) tick();
    chk("pre_rst_flags", {30'b0, new_flags}, 32'h2);
    enter[1] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_led", {8'b0, led_out}, 32'h0);
    chk("async_flags", {30'b0, new_flags}, 32'h0);
    chk("rst_mux_mem", bus_if.rdata, 32'h1122_3344);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    read_chk("post_rst_ch0", BASE, 32'h0);
    read_chk("post_rst_ch1", BASE + 32'h4, 32'h0);
    read_chk("post_rst_led", BASE + 32'h30, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_bus_ctrl.md
# io_bus_ctrl

Parametrised memory-mapped IO controller between the CPU's data-memory path and board IO. It generalises the single-pair switch/LED block to NUM_CH latched switch channels and adds several behaviours: synchronised and optionally debounced enter buttons, per-channel new-data status flags with clear-on-read, a write-data-driven LED register, and address-decoded readback. It sits beside data memory and muxes its register reads into the load-result path.

## Interface
Parameters:
- NUM_CH, 2: number of latched switch channels, 1..8.
- IN_W, 8: switch width per channel, 1..32.
- LED_W, 24: LED register width, 1..32.
- TEST_W, 3: test-switch width, 1..32.
- IO_BASE, 32'hFFFF_FC00: base address, word-aligned.
- DB_CYCLES, 1_000_000: debounce stable-cycle count, ≥1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- io_read  in  1  CPU load targets IO.
- io_write  in  1  CPU store targets IO.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data.
- mem_rdata  in  32  data-memory read data.
- sw_in  in  IN_W  shared switch bank.
- enter  in  NUM_CH  raw button per channel; channel k latches sw_in.
- test_in  in  TEST_W  test-mode switches.
- rdata  out  32  load result to writeback.
- led_out  out  LED_W  LED drive, equal to the LED register.
- new_flags  out  NUM_CH  status flags, also readable.

## Operation
Register map (byte offsets from IO_BASE):
- CH[k]: 4·k, k<NUM_CH; read-only; {zero, ch_data[k]}.
- TEST: 0x20; read-only; zero-extended test_in.
- STATUS: 0x24; read-only; zero-extended new_flags; reading it does not clear the flags.
- LED: 0x30; read/write; a write stores wdata[LED_W-1:0], a read returns the value zero-extended.

Input path:
- sw_in, test_in and enter each pass through a 2-FF synchroniser.
- Edge detect: the stage registers the previous conditioned enter level. A 0→1 transition of the conditioned level for channel k loads ch_data[k] with the synchronised sw_in and sets new_flags[k].
- A level held high produces one latch only.
- Clear-on-read: io_read with addr==CH[k] clears new_flags[k] at that edge.
- Set and clear in the same cycle: set wins.

Read mux (combinational):
- io_read=1 and addr matches a mapped register: rdata = that register.
- Otherwise rdata = mem_rdata. This includes io_read=0, unmapped IO addresses, and CH[k] with k≥NUM_CH.

Writes:
- Only io_write with addr==LED updates state.
- Writes to any other address are ignored.

Reset (rst_n=0, asynchronous):
- ch_data, new_flags, LED register, synchronisers, edge registers and debounce state/counters all go to 0.
- led_out=0 and new_flags=0 immediately.
- rdata still follows the mux, so it equals mem_rdata while io_read=0.
- A reset asserted mid-debounce discards the partial count.

## Timing
- Loads: rdata is valid in the same cycle as addr/io_read (zero latency).
- LED store: led_out updates at the rising edge where io_write=1.
- Latch latency without debounce: enter rises before edge 0 → ch_data and new_flag update at edge 2 (two synchroniser edges, then the edge-detect edge).
- Latch latency with debounce: DB_CYCLES later than the non-debounced case.
- new_flags: the clear is visible the cycle after the read edge.
- io_read and io_write are never both asserted; behaviour in that case is undefined.

## Configuration
- IO_DEBOUNCE_EN defined:
  - Each synchronised enter feeds a debouncer. The debounced level toggles only after the synchronised input has differed from it for DB_CYCLES consecutive cycles.
  - Any mismatch-free cycle resets the counter to 0.
  - Edge detect operates on the debounced level.
- IO_DEBOUNCE_EN undefined:
  - No counters are instantiated.
  - Edge detect operates directly on the synchroniser output.
  - DB_CYCLES is ignored.

## Test plan
- Reset: rst_n low mid-operation with LED=0xABCDEF → led_out=0 and new_flags=0 asynchronously. After release, a read of CH[0] returns 0.
- Latch: NUM_CH=2, sw_in=0x5A, pulse enter[1] for 4 cycles (no debounce) → CH[1] reads 0x0000005A and new_flags=2'b10; CH[0] remains 0. Holding enter high produces no second latch.
- Status: after the latch, read STATUS → 0x2 with the flag still set. Read CH[1] → new_flags=0 the next cycle. Latch coinciding with the read edge → flag stays 1.
- LED/mux: store 0x12345678 to LED with LED_W=24 → led_out=0x345678 and LED reads 0x00345678. Store to CH[0] → no change. Load from IO_BASE+0x38 → mem_rdata. TEST reads zero-extended test_in=3'b101 → 0x5.
- Debounce (IO_DEBOUNCE_EN, DB_CYCLES=8): enter bounces 3 high / 2 low repeatedly → no latch. Held high 8+ cycles → exactly one latch, DB_CYCLES later than the non-debounced case.
